spi_tx: RTL and testbench

SPI master transmit engine for the SPI controller: accepts parallel words over a valid/ready handshake and serializes them MSB-first on `sdo_o`. It drives `sclk_o` and `cs_n_o` according to CPOL/CPHA. Bit timing comes from the shared SPI clock generator's `bit_en` strobe; this block requests that strobe through `clk_gen`. It sits beside the SPI receive path and shares the same mode inputs.

---
 rtl/spi_tx.sv | 167 ++++++++++++++++
 tb/tb_spi_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx.sv
// SPI master transmit engine: one-deep holding buffer feeding an MSB-first shifter.
// Bit timing comes from the shared clock generator's bit_en strobe (one per SCLK half-period).
module spi_tx #(
    parameter int DLY        = 1,
    parameter int FIFO_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpol,
    input  logic                  cpoa,
    input  logic [FIFO_WIDTH-1:0] tx_wdata_i,
    input  logic                  tx_vld_i,
    output logic                  tx_rdy_o,
    input  logic                  bit_en,
    output logic                  clk_gen,
    output logic                  tx_busy_o,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  sdo_o
);

    localparam int                CNT_W     = $clog2(2 * FIFO_WIDTH);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * FIFO_WIDTH - 1);

    // DLY is kept so existing instantiations still bind; registers update without delay.
    if (FIFO_WIDTH < 2 || DLY < 0) begin : g_param_check
        $error("spi_tx: FIFO_WIDTH must be at least 2 and DLY non-negative");
    end

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_LEAD  = 4'b0010,
        S_SHIFT = 4'b0100,
        S_TRAIL = 4'b1000
    } state_e;

    state_e                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_vld_q, buf_vld_d;
    logic [FIFO_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic                    cpol_l_q, cpol_l_d;
    logic                    cpha_l_q, cpha_l_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sdo_q, sdo_d;

    // NOTE: every register, including the word buffer and shifter, is reset so a
    // mid-frame reset leaves no stale word behind to be transmitted afterwards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            shift_q    <= '0;
            edge_cnt_q <= '0;
            cpol_l_q   <= 1'b0;
            cpha_l_q   <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sdo_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge
            // values regardless of statement order.
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            shift_q    <= shift_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_l_q   <= cpol_l_d;
            cpha_l_q   <= cpha_l_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            sdo_q      <= sdo_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no path through the case
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        shift_d    = shift_q;
        edge_cnt_d = edge_cnt_q;
        cpol_l_d   = cpol_l_q;
        cpha_l_d   = cpha_l_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        sdo_d      = sdo_q;

        // Accept and transfer never coincide: accept needs an empty buffer, transfer a full one.
        if (tx_vld_i && !buf_vld_q) begin
            buf_d     = tx_wdata_i;
            buf_vld_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                cs_n_d = 1'b1;
                sdo_d  = 1'b0;
                if (bit_en && buf_vld_q) begin
                    state_d    = S_LEAD;
                    shift_d    = buf_q;
                    buf_vld_d  = 1'b0;
                    cpol_l_d   = cpol;
                    cpha_l_d   = cpoa;
                    cs_n_d     = 1'b0;
                    edge_cnt_d = '0;
                    sdo_d      = cpoa ? 1'b0 : buf_q[FIFO_WIDTH-1];
                end
            end

            S_LEAD: begin
                if (bit_en) begin
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_en) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q == LAST_EDGE) begin
                        sclk_d  = cpol_l_q;
                        state_d = S_TRAIL;
                    end else if (!cpha_l_q && edge_cnt_q[0]) begin
                        // Phase 0: the MSB went out with CS; later bits change on trailing edges.
                        shift_d = shift_q << 1;
                        sdo_d   = shift_q[FIFO_WIDTH-2];
                    end else if (cpha_l_q && !edge_cnt_q[0]) begin
                        if (edge_cnt_q == '0) begin
                            sdo_d = shift_q[FIFO_WIDTH-1];
                        end else begin
                            shift_d = shift_q << 1;
                            sdo_d   = shift_q[FIFO_WIDTH-2];
                        end
                    end
                end
            end

            S_TRAIL: begin
                if (bit_en) begin
                    state_d = S_IDLE;
                    sclk_d  = cpol_l_q;
                    cs_n_d  = 1'b1;
                    sdo_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sdo_d   = 1'b0;
            end
        endcase
    end

    assign tx_rdy_o  = !buf_vld_q;
    assign tx_busy_o = (state_q != S_IDLE);
    assign clk_gen   = (state_q != S_IDLE) || buf_vld_q;
    assign sclk_o    = sclk_q;
    assign cs_n_o    = cs_n_q;
    assign sdo_o     = sdo_q;

endmodule

// File: tb/tb_spi_tx.sv
// Directed self-checking bench for spi_tx at W=8 with bit_en every 4 clocks;
// a negedge monitor decodes each frame from sclk_o/cs_n_o/sdo_o.
module tb_spi_tx;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         cpol     = 1'b0;
    logic         cpoa     = 1'b0;
    logic [W-1:0] tx_wdata = '0;
    logic         tx_vld   = 1'b0;
    logic         bit_en   = 1'b0;
    logic         tx_rdy_o, clk_gen, tx_busy_o, sclk_o, cs_n_o, sdo_o;

    int checks = 0;
    int errors = 0;

    spi_tx #(.DLY(1), .FIFO_WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cpol       (cpol),
        .cpoa       (cpoa),
        .tx_wdata_i (tx_wdata),
        .tx_vld_i   (tx_vld),
        .tx_rdy_o   (tx_rdy_o),
        .bit_en     (bit_en),
        .clk_gen    (clk_gen),
        .tx_busy_o  (tx_busy_o),
        .sclk_o     (sclk_o),
        .cs_n_o     (cs_n_o),
        .sdo_o      (sdo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Strobe generator and frame monitor share one negedge process so the
    // strobe the monitor sees is the one the DUT sampled at the preceding posedge.
    logic         run_en    = 1'b1;
    int           gen_cnt   = 0;
    logic         prev_cs   = 1'b1;
    logic         prev_sclk = 1'b0;
    logic         prev_sdo  = 1'b0;
    int           gap_strobes = 0, cur_gap = 0;
    int           cur_strobes = 0, cur_edges = 0, cur_bits = 0, cur_bad = 0;
    logic [W-1:0] cur_data  = '0;
    int           start_cnt = 0, frame_cnt = 0;
    logic [W-1:0] fr_data [16];
    int           fr_strobes [16];
    int           fr_edges [16];
    int           fr_bits [16];
    int           fr_bad [16];
    int           fr_gap [16];
    logic         fr_sclk_end [16];

    always @(negedge clk) begin
        if (bit_en) begin
            if (prev_cs) gap_strobes++;
            else         cur_strobes++;
        end
        if (prev_cs && !cs_n_o) begin
            cur_gap     = gap_strobes;
            gap_strobes = 0;
            cur_strobes = 0;
            cur_edges   = 0;
            cur_bits    = 0;
            cur_bad     = 0;
            cur_data    = '0;
            start_cnt++;
        end
        if (!prev_cs && !cs_n_o) begin
            if (sclk_o !== prev_sclk) cur_edges++;
            if (!prev_sclk && sclk_o) begin
                cur_data = {cur_data[W-2:0], sdo_o};
                cur_bits++;
            end
            if (sdo_o !== prev_sdo && !(prev_sclk && !sclk_o)) cur_bad++;
        end
        if (!prev_cs && cs_n_o) begin
            if (frame_cnt < 16) begin
                fr_data[frame_cnt]     = cur_data;
                fr_strobes[frame_cnt]  = cur_strobes;
                fr_edges[frame_cnt]    = cur_edges;
                fr_bits[frame_cnt]     = cur_bits;
                fr_bad[frame_cnt]      = cur_bad;
                fr_gap[frame_cnt]      = cur_gap;
                fr_sclk_end[frame_cnt] = sclk_o;
            end
            frame_cnt++;
        end
        prev_cs   = cs_n_o;
        prev_sclk = sclk_o;
        prev_sdo  = sdo_o;
        if (run_en) begin
            gen_cnt = (gen_cnt == 3) ? 0 : gen_cnt + 1;
            bit_en  = (gen_cnt == 3);
        end else begin
            bit_en  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n = 0;
        while (start_cnt < target && n < 2000) begin tick(); n++; end
        check(tag, 32'(start_cnt >= target), 32'd1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frame_cnt < target && n < 2000) begin tick(); n++; end
        check(tag, 32'(frame_cnt >= target), 32'd1);
    endtask

    task automatic wait_edges(input int target, input string tag);
        int n = 0;
        while (cur_edges < target && n < 2000) begin tick(); n++; end
        check(tag, 32'(cur_edges >= target), 32'd1);
    endtask

    task automatic push(input logic [W-1:0] w, input string tag);
        int n = 0;
        tx_wdata = w;
        tx_vld   = 1'b1;
        while (!tx_rdy_o && n < 2000) begin tick(); n++; end
        check({tag, "_rdy"}, 32'(tx_rdy_o), 32'd1);
        tick();
        tx_vld = 1'b0;
        check({tag, "_full"}, 32'(tx_rdy_o), 32'd0);
    endtask

    task automatic check_frame(input int idx, input string tag, input logic [W-1:0] exp_data,
                               input logic exp_sclk_end);
        check({tag, "_data"},  32'(fr_data[idx]), 32'(exp_data));
        check({tag, "_bits"},  32'(fr_bits[idx]), 32'd8);
        check({tag, "_edges"}, 32'(fr_edges[idx]), 32'd16);
        check({tag, "_sdochg"}, 32'(fr_bad[idx]), 32'd0);
        check({tag, "_sclkend"}, 32'(fr_sclk_end[idx]), 32'(exp_sclk_end));
    endtask

    initial begin
        int b, s, diffs, low_cycles;
        logic [4:0] snap;

        #2 rst_n = 1'b0;
        #1;
        check("rst_sclk", 32'(sclk_o), 32'd0);
        check("rst_cs_n", 32'(cs_n_o), 32'd1);
        check("rst_sdo", 32'(sdo_o), 32'd0);
        check("rst_busy", 32'(tx_busy_o), 32'd0);
        check("rst_rdy", 32'(tx_rdy_o), 32'd1);
        check("rst_clk_gen", 32'(clk_gen), 32'd0);
        cpol = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_sclk_cpol1", 32'(sclk_o), 32'd1);
        cpol = 1'b0;
        tick();
        tick();
        check("idle_sclk_cpol0", 32'(sclk_o), 32'd0);

        // Mode 0: 0xA5
        b = frame_cnt;
        push(8'hA5, "m0");
        check("m0_clk_gen", 32'(clk_gen), 32'd1);
        wait_frames(b + 1, "m0_done");
        check_frame(b, "m0", 8'hA5, 1'b0);
        check("m0_strobes", 32'(fr_strobes[b]), 32'd18);
        tick();
        check("m0_idle_busy", 32'(tx_busy_o), 32'd0);

        // Mode 3: 0x3C
        cpol = 1'b1;
        cpoa = 1'b1;
        tick();
        tick();
        check("m3_idle_sclk", 32'(sclk_o), 32'd1);
        b = frame_cnt;
        push(8'h3C, "m3");
        wait_frames(b + 1, "m3_done");
        check_frame(b, "m3", 8'h3C, 1'b1);
        check("m3_strobes", 32'(fr_strobes[b]), 32'd18);

        // Back-to-back queued words in mode 0
        cpol = 1'b0;
        cpoa = 1'b0;
        tick();
        b = frame_cnt;
        s = start_cnt;
        push(8'h11, "q1");
        push(8'h22, "q2");
        check("q2_during_frame", 32'(tx_busy_o), 32'd1);
        check("q2_first_open", 32'(frame_cnt), 32'(b));
        wait_starts(s + 2, "q2_start");
        check("q2_rdy_reopen", 32'(tx_rdy_o), 32'd1);
        wait_frames(b + 2, "q_done");
        check_frame(b, "q1", 8'h11, 1'b0);
        check_frame(b + 1, "q2", 8'h22, 1'b0);
        check("q_gap", 32'(fr_gap[b + 1] >= 1), 32'd1);

        // bit_en stalled for 50 cycles mid-SHIFT
        b = frame_cnt;
        s = start_cnt;
        push(8'hC3, "st");
        wait_starts(s + 1, "st_start");
        wait_edges(6, "st_edges");
        run_en = 1'b0;
        tick();
        tick();
        snap  = {sclk_o, cs_n_o, sdo_o, tx_busy_o, tx_rdy_o};
        diffs = 0;
        repeat (50) begin
            tick();
            if ({sclk_o, cs_n_o, sdo_o, tx_busy_o, tx_rdy_o} !== snap) diffs++;
        end
        check("st_hold", 32'(diffs), 32'd0);
        check("st_cs_low", 32'(cs_n_o), 32'd0);
        run_en = 1'b1;
        wait_frames(b + 1, "st_done");
        check_frame(b, "st", 8'hC3, 1'b0);

        // Asynchronous reset at edge k=5, with a second word buffered
        b = frame_cnt;
        s = start_cnt;
        push(8'h0F, "ra");
        wait_starts(s + 1, "ra_start");
        push(8'h77, "rb");
        wait_edges(5, "ra_edges");
        rst_n = 1'b0;
        #1;
        check("ra_cs_n", 32'(cs_n_o), 32'd1);
        check("ra_sdo", 32'(sdo_o), 32'd0);
        check("ra_rdy", 32'(tx_rdy_o), 32'd1);
        check("ra_busy", 32'(tx_busy_o), 32'd0);
        check("ra_sclk", 32'(sclk_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        low_cycles = 0;
        repeat (40) begin
            tick();
            if (cs_n_o !== 1'b1) low_cycles++;
        end
        check("ra_no_frame", 32'(low_cycles), 32'd0);
        check("ra_frames", 32'(frame_cnt), 32'(b + 1));
        b = frame_cnt;
        push(8'h96, "rc");
        wait_frames(b + 1, "rc_done");
        check_frame(b, "rc", 8'h96, 1'b0);

        // cpol toggled mid-frame: frame keeps latched polarity
        b = frame_cnt;
        s = start_cnt;
        push(8'h5A, "pt");
        wait_starts(s + 1, "pt_start");
        wait_edges(3, "pt_edges");
        cpol = 1'b1;
        wait_frames(b + 1, "pt_done");
        check_frame(b, "pt", 8'h5A, 1'b0);
        tick();
        tick();
        check("pt_idle_sclk", 32'(sclk_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
